regbank_mp: RTL
===============

Name: regbank_mp

Overview:
- Parametrised, clocked successor of the core register bank. It holds NREG general registers, including the PC at index PC_IDX, plus a CPSR.
- Provides NRD independent read ports with a req/valid handshake, one writeback port, a dedicated fetch PC port and a CPSR port.
- Adds a per-register pending-write scoreboard: the issue stage locks a destination, and reads of a locked register stall until writeback clears the lock.
- Sits between decode/issue (reads, locks), writeback (writes), fetch (PC) and issue (CPSR).

Parameters:
DATA_W, 32, register and data width
ADDR_W, 4, register address width; NREG = 2**ADDR_W
NRD, 2, number of read ports
PC_IDX, 15, index of the PC register
BYPASS, 1, 1 = same-cycle writeback forwarding to waiting reads; 0 = no forwarding

Ports:
clk  in  1  the one clock; all state updates on its rising edge
rst  in  1  reset, synchronous and active-high
rd_req  in  NRD  per-port read request, level
rd_addr  in  NRD*ADDR_W  per-port register address, port i at bits [i*ADDR_W +: ADDR_W]
rd_valid  out  NRD  per-port one-cycle response strobe
rd_data  out  NRD*DATA_W  per-port read data, port i at [i*DATA_W +: DATA_W]
wr_en  in  1  writeback write enable
wr_addr  in  ADDR_W  writeback address
wr_data  in  DATA_W  writeback data
lock_en  in  1  mark lock_addr pending (issue stage)
lock_addr  in  ADDR_W  register to lock
pc_we  in  1  fetch PC update
pc_in  in  DATA_W  next PC value
pc_out  out  DATA_W  current PC register value
cpsr_we  in  1  CPSR update
cpsr_in  in  DATA_W  new CPSR value
cpsr_out  out  DATA_W  current CPSR
busy  out  NREG  scoreboard, bit r = register r pending

Behaviour:
- Reset (synchronous, active-high): all registers, CPSR, busy, rd_valid and rd_data go to 0. Outstanding reads are dropped with no rd_valid. Reset overrides all same-cycle inputs.
- Read port FSM, per port, ports fully independent:
  - IDLE: on rd_req, if busy[addr]==0, go to RESP. Otherwise go to WAIT.
  - WAIT: when busy[addr] clears, go to RESP. With BYPASS=1, a write to addr in the same cycle also completes the read, returning wr_data.
  - RESP: rd_valid=1 for exactly one cycle with rd_data registered, then back to IDLE.
  - Latency: a non-pending read returns rd_valid on the cycle after rd_req is sampled (1 cycle).
  - Requester holds rd_req and rd_addr stable until rd_valid. rd_req may be re-asserted on the cycle rd_valid is high; it is sampled in IDLE on the next cycle.
- Writes:
  - wr_en writes mem[wr_addr] and clears busy[wr_addr].
  - A same-cycle non-pending read of wr_addr returns wr_data when BYPASS=1 and the old value when BYPASS=0.
  - A WAIT read with BYPASS=0 completes one cycle after the write.
- Locks:
  - lock_en sets busy[lock_addr].
  - Lock and write to the same address in the same cycle: set wins, and the register stays busy.
  - Locking an already-busy register keeps it busy.
- PC:
  - pc_we writes mem[PC_IDX].
  - If wr_en targets PC_IDX in the same cycle, wr_en wins and pc_in is discarded.
  - pc_out = mem[PC_IDX], combinational from the register, so an update is visible from the cycle after the write.
- CPSR: cpsr_we loads cpsr_in. cpsr_out is the register, updated one cycle after cpsr_we.
- busy output is the scoreboard register, driven directly.
- Reads of PC_IDX follow the same rules and may be locked.
- Multiple ports reading the same register in the same cycle all receive identical data.

Test Plan:
- Reset, then write r3=0xDEADBEEF; port0 reads r3, port1 reads r15 -> next cycle rd_valid=2'b11, rd_data0=0xDEADBEEF, rd_data1=0.
- Lock r5; port0 reads r5 -> stays in WAIT, rd_valid=0 for 5 cycles. Write r5=0x1234 with BYPASS=1 -> rd_valid0 on the write cycle+1 with 0x1234, busy[5]=0. Repeat with BYPASS=0 -> response one cycle later, same data.
- Same cycle lock_en and wr_en to r7 -> busy[7]=1 and mem[7]=wr_data; a subsequent read stalls.
- pc_we pc_in=0x100 with wr_en r15=0x200 in the same cycle -> pc_out=0x200 next cycle. pc_we alone with 0x104 -> pc_out=0x104.
- cpsr_we cpsr_in=0x6000001F -> cpsr_out=0x6000001F next cycle.
- Assert rst while port1 is in WAIT on a locked r2 -> rd_valid never pulses, busy=0, all outputs 0 the cycle after rst.

Source files
------------

// File: rtl/regbank_mp.sv
// Register bank with NREG GPRs (PC included), CPSR, NRD handshaked read ports and a pending-write scoreboard.
// Reads of free registers respond 1 cycle after sampling; reads of locked registers stall until writeback.
module regbank_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int NRD    = 2,
    parameter int PC_IDX = 15,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NRD-1:0]           rd_req,
    input  logic [NRD*ADDR_W-1:0]    rd_addr,
    output logic [NRD-1:0]           rd_valid,
    output logic [NRD*DATA_W-1:0]    rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     lock_en,
    input  logic [ADDR_W-1:0]        lock_addr,
    input  logic                     pc_we,
    input  logic [DATA_W-1:0]        pc_in,
    output logic [DATA_W-1:0]        pc_out,
    input  logic                     cpsr_we,
    input  logic [DATA_W-1:0]        cpsr_in,
    output logic [DATA_W-1:0]        cpsr_out,
    output logic [(2**ADDR_W)-1:0]   busy
);

    localparam int NREG = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [DATA_W-1:0] mem [NREG];
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_next;
    logic [DATA_W-1:0] cpsr_q;
    logic [1:0]        st [NRD];
    logic [DATA_W-1:0] data_q [NRD];

    logic [ADDR_W-1:0] addr [NRD];
    logic [NRD-1:0]    hit;
    logic [DATA_W-1:0] fwd [NRD];

    // hit marks a same-cycle writeback that may be forwarded to port i
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            addr[i] = rd_addr[i*ADDR_W +: ADDR_W];
            hit[i]  = (BYPASS != 0) && wr_en && (wr_addr == addr[i]);
            fwd[i]  = hit[i] ? wr_data : mem[addr[i]];
        end
    end

    // Lock is applied after the clear so that a same-cycle lock wins
    always_comb begin
        busy_next = busy_q;
        if (wr_en)
            busy_next[wr_addr] = 1'b0;
        if (lock_en)
            busy_next[lock_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++)
                mem[r] <= '0;
            busy_q <= '0;
            cpsr_q <= '0;
            for (int i = 0; i < NRD; i++) begin
                st[i]     <= S_IDLE;
                data_q[i] <= '0;
            end
        end else begin
            if (pc_we && !(wr_en && (wr_addr == PC_A)))
                mem[PC_A] <= pc_in;
            if (wr_en)
                mem[wr_addr] <= wr_data;
            busy_q <= busy_next;
            if (cpsr_we)
                cpsr_q <= cpsr_in;

            for (int i = 0; i < NRD; i++) begin
                case (st[i])
                    S_IDLE: begin
                        if (rd_req[i]) begin
                            if (!busy_q[addr[i]]) begin
                                st[i]     <= S_RESP;
                                data_q[i] <= fwd[i];
                            end else begin
                                st[i] <= S_WAIT;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (hit[i] || !busy_q[addr[i]]) begin
                            st[i]     <= S_RESP;
                            data_q[i] <= fwd[i];
                        end
                    end
                    S_RESP:  st[i] <= S_IDLE;
                    default: st[i] <= S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        rd_valid = '0;
        rd_data  = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_valid[i]                 = (st[i] == S_RESP);
            rd_data[i*DATA_W +: DATA_W] = data_q[i];
        end
    end

    assign pc_out   = mem[PC_A];
    assign cpsr_out = cpsr_q;
    assign busy     = busy_q;

endmodule
